bcd_serial_addsub: RTL

- Multi-digit, digit-serial BCD adder/subtractor; successor to the single-digit serial BCD adder.
- Captures two packed DIGITS-wide BCD operands on a start handshake and processes one digit per clock, LSD first.
- Presents the packed result plus carry/borrow with a one-cycle done pulse.
- Used by the decimal datapath wherever a full-width BCD add or subtract is needed without a DIGITS-wide parallel adder.

---
 rtl/bcd_serial_addsub.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial multi-digit BCD adder/subtractor, LSD first
// Optional input checking enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                sub,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry,
  output logic                invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_sr;
  logic [W-1:0]   b_sr;
  logic [W-1:0]   res_sr;
  logic [CW-1:0]  cnt;
  logic           c_q;
  logic           sub_q;
  logic           bad_q;

  logic [3:0]     b_eff;
  logic [4:0]     s;
  logic           gt9;
  logic [3:0]     digit;
  logic [W-1:0]   res_next;
  logic           start_bad;

  // Subtraction adds the nines complement of b; the preloaded carry makes it tens complement.
  always_comb begin
    b_eff    = sub_q ? (4'd9 - b_sr[3:0]) : b_sr[3:0];
    s        = {1'b0, a_sr[3:0]} + {1'b0, b_eff} + {4'b0000, c_q};
    gt9      = s[4] | (s[3] & (s[2] | s[1]));
    digit    = gt9 ? (s[3:0] + 4'd6) : s[3:0];
    res_next = (res_sr >> 4) | (W'(digit) << (W - 4));
  end

  always_comb begin
    start_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) start_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      invalid <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start && !clear) begin
            a_sr  <= a;
            b_sr  <= b;
            sub_q <= sub;
            c_q   <= sub;
            cnt   <= '0;
            bad_q <= start_bad;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (clear) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sr   <= a_sr >> 4;
            b_sr   <= b_sr >> 4;
            res_sr <= res_next;
            c_q    <= gt9;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(DIGITS - 1)) begin
              result <= res_next;
              carry  <= sub_q ? ~gt9 : gt9;
`ifdef BCD_INPUT_CHECK_EN
              invalid <= bad_q;
`else
              invalid <= 1'b0;
`endif
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
